debounce_switch_array: RTL and testbench

- Multi-channel successor to the single-switch debouncer.
- Each channel synchronises a raw pin, debounces it with a stable-time counter, and emits press/release strobes.
- Each channel also emits a long-press strobe and an auto-repeat strobe while held.
- Sits between board buttons/switches and game/UI logic, e.g. paddle controls and menus.

---
 rtl/debounce_switch_array.sv | 152 +++++++++++++++
 tb/tb_debounce_switch_array.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_switch_array.sv
// Multi-channel switch debouncer: per-channel synchroniser, stable-time debounce,
// press/release strobes and a hold FSM producing long-press and auto-repeat strobes.
module debounce_switch_array #(
   parameter int                NUM_CH          = 4,
   parameter int                DEBOUNCE_LIMIT  = 250000,
   parameter int                SYNC_STAGES     = 2,
   parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = {NUM_CH{1'b0}},
   parameter int                LONG_LIMIT      = 25000000,
   parameter int                REPEAT_PERIOD   = 5000000
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic [NUM_CH-1:0] i_Switch,
   output logic [NUM_CH-1:0] o_State,
   output logic [NUM_CH-1:0] o_Press,
   output logic [NUM_CH-1:0] o_Release,
   output logic [NUM_CH-1:0] o_Long,
   output logic [NUM_CH-1:0] o_Repeat
);

   localparam int DW       = $clog2(DEBOUNCE_LIMIT + 1);
   localparam int HOLD_MAX = (LONG_LIMIT > REPEAT_PERIOD) ? LONG_LIMIT : REPEAT_PERIOD;
   localparam int HW       = $clog2(HOLD_MAX + 1);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_LIMIT - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_LIMIT - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_PERIOD > 0) ? (REPEAT_PERIOD - 1) : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      LONG = 2'd2
   } hold_state_t;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   s;
         logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
         logic                   state_q, state_d;
         logic                   state_dly_q;
         logic                   press_q, release_q;
         logic                   commit_press, commit_release;
         hold_state_t            hold_st_q, hold_st_d;
         logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
         logic                   long_q, long_d;
         logic                   rep_q, rep_d;

         // Synchroniser resets to the mask so the logical level starts released.
         always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
               sync_q <= {SYNC_STAGES{ACTIVE_LOW_MASK[gi]}};
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], i_Switch[gi]};
            end
         end

         assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK[gi];

         always_comb begin
            deb_cnt_d = '0;
            state_d   = state_q;
            if (s != state_q) begin
               if (deb_cnt_q == DEB_LAST) begin
                  state_d = s;
               end else begin
                  deb_cnt_d = deb_cnt_q + 1'b1;
               end
            end
         end

         assign commit_press   = state_d & ~state_q;
         assign commit_release = ~state_d & state_q;

         always_comb begin
            hold_st_d  = hold_st_q;
            hold_cnt_d = hold_cnt_q;
            long_d     = 1'b0;
            rep_d      = 1'b0;
            // A release commit wins over any long/repeat due on the same edge.
            if (commit_release) begin
               hold_st_d  = IDLE;
               hold_cnt_d = '0;
            end else if (commit_press) begin
               hold_st_d  = HELD;
               hold_cnt_d = '0;
            end else begin
               case (hold_st_q)
                  HELD: begin
                     if (hold_cnt_q == LONG_LAST) begin
                        long_d     = 1'b1;
                        hold_st_d  = LONG;
                        hold_cnt_d = '0;
                     end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                     end
                  end
                  LONG: begin
                     if (REPEAT_PERIOD > 0) begin
                        if (hold_cnt_q == REP_LAST) begin
                           rep_d      = 1'b1;
                           hold_cnt_d = '0;
                        end else begin
                           hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                     end
                  end
                  IDLE: begin
                     hold_cnt_d = '0;
                  end
                  default: begin
                     hold_st_d  = IDLE;
                     hold_cnt_d = '0;
                  end
               endcase
            end
         end

         always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
               deb_cnt_q   <= '0;
               state_q     <= 1'b0;
               state_dly_q <= 1'b0;
               press_q     <= 1'b0;
               release_q   <= 1'b0;
               hold_st_q   <= IDLE;
               hold_cnt_q  <= '0;
               long_q      <= 1'b0;
               rep_q       <= 1'b0;
            end else begin
               deb_cnt_q   <= deb_cnt_d;
               state_q     <= state_d;
               state_dly_q <= state_q;
               press_q     <= state_q & ~state_dly_q;
               release_q   <= ~state_q & state_dly_q;
               hold_st_q   <= hold_st_d;
               hold_cnt_q  <= hold_cnt_d;
               long_q      <= long_d;
               rep_q       <= rep_d;
            end
         end

         assign o_State[gi]   = state_q;
         assign o_Press[gi]   = press_q;
         assign o_Release[gi] = release_q;
         assign o_Long[gi]    = long_q;
         assign o_Repeat[gi]  = rep_q;
      end
   endgenerate

endmodule

// File: tb/tb_debounce_switch_array.sv
// Self-checking bench: directed scenarios plus random pin activity, compared every
// cycle against a sample-window / hold-time reference model.
module tb_debounce_switch_array;

   localparam int         NCH  = 2;
   localparam int         DL   = 4;
   localparam int         SS   = 2;
   localparam int         LL   = 20;
   localparam int         RP   = 8;
   localparam logic [1:0] MASK = 2'b10;
   localparam int         HLEN = 8192;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] sw    = 2'b10;

   logic [1:0] st, pr, rl, lg, rp;
   logic [1:0] st_n, pr_n, rl_n, lg_n, rp_n;

   always #5 clk = ~clk;

   debounce_switch_array #(
      .NUM_CH(NCH), .DEBOUNCE_LIMIT(DL), .SYNC_STAGES(SS),
      .ACTIVE_LOW_MASK(MASK), .LONG_LIMIT(LL), .REPEAT_PERIOD(RP)
   ) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
      .o_State(st), .o_Press(pr), .o_Release(rl), .o_Long(lg), .o_Repeat(rp)
   );

   debounce_switch_array #(
      .NUM_CH(NCH), .DEBOUNCE_LIMIT(DL), .SYNC_STAGES(SS),
      .ACTIVE_LOW_MASK(MASK), .LONG_LIMIT(LL), .REPEAT_PERIOD(0)
   ) dut_nr (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw),
      .o_State(st_n), .o_Press(pr_n), .o_Release(rl_n), .o_Long(lg_n), .o_Repeat(rp_n)
   );

   int checks = 0;
   int passes = 0;

   // Reference model: logical pin history indexed by cycle since reset release.
   bit         hist [NCH][HLEN];
   int         cyc;
   logic [1:0] m_st, m_prev;
   int         tc [NCH];
   logic [1:0] e_press, e_rel, e_long, e_rep;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      cyc = 0;
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < SS + DL; k++) hist[c][k] = 1'b0;
         tc[c] = 0;
      end
      m_st = '0; m_prev = '0;
      e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
   endtask

   task automatic model_edge();
      cyc++;
      for (int c = 0; c < NCH; c++) begin
         int  base, idx, h;
         bit  flip;
         logic old;
         base = cyc + SS + DL - 1;
         hist[c][base] = sw[c] ^ MASK[c];
         idx = base - SS;
         // Commit when the last DL synchronised samples all disagree with the state.
         flip = 1'b1;
         for (int k = 0; k < DL; k++) if (hist[c][idx-k] == m_st[c]) flip = 1'b0;
         old        = m_st[c];
         e_press[c] = m_st[c] & ~m_prev[c];
         e_rel[c]   = ~m_st[c] & m_prev[c];
         m_prev[c]  = m_st[c];
         if (flip) m_st[c] = ~m_st[c];
         e_long[c] = 1'b0;
         e_rep[c]  = 1'b0;
         if (m_st[c] && !old) begin
            tc[c] = cyc;
         end else if (m_st[c]) begin
            h = cyc - tc[c];
            e_long[c] = (h == LL);
            e_rep[c]  = (h > LL) && (((h - LL) % RP) == 0);
         end
      end
   endtask

   task automatic check_all();
      chk("state", st, m_st);
      chk("press", pr, e_press);
      chk("release", rl, e_rel);
      chk("long", lg, e_long);
      chk("repeat", rp, e_rep);
      chk("nr_state", st_n, m_st);
      chk("nr_press", pr_n, e_press);
      chk("nr_release", rl_n, e_rel);
      chk("nr_long", lg_n, e_long);
      chk("nr_repeat", rp_n, 2'b00);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check_all();
      if ((e_press | e_rel | e_long | e_rep) != 2'b00)
         $display("cyc %0d sw=%b state=%b press=%b release=%b long=%b repeat=%b",
                  cyc, sw, m_st, e_press, e_rel, e_long, e_rep);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int n, n_long, n_rep, long_off, last_rep_off, n_rel, n_long_nr, n_rep_nr, dur;
      model_reset();

      // 1: reset with both channels released, then idle
      ticks(3);
      rst_n = 1'b1;
      ticks(50);
      $display("step1 idle after reset done");

      // 2: short glitch rejected, then clean press with latency check
      sw[0] = 1'b1; ticks(3);
      sw[0] = 1'b0; ticks(10);
      sw[0] = 1'b1;
      n = 0;
      while (!st[0] && n < 30) begin tick(); n++; end
      chk_int("press_latency", n, SS + DL);
      tick();
      chk("press_strobe", pr, 2'b01);
      $display("step2 press committed after %0d cycles", n);

      // 3: long press and repeats, release before the fifth repeat
      n_long = 0; n_rep = 0; long_off = -1; last_rep_off = -1; n_rel = 0;
      for (int off = 2; off <= 53; off++) begin
         tick();
         if (lg[0]) begin n_long++; long_off = off; end
         if (rp[0]) begin n_rep++; last_rep_off = off; end
      end
      sw[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (lg[0]) n_long++;
         if (rp[0]) n_rep++;
         if (rl[0]) n_rel++;
      end
      chk_int("long_count", n_long, 1);
      chk_int("long_offset", long_off, LL);
      chk_int("repeat_count", n_rep, 4);
      chk_int("last_repeat_offset", last_rep_off, LL + 4 * RP);
      chk_int("release_count", n_rel, 1);
      chk("released_state", st, 2'b00);
      $display("step3 long/repeat sequence done");

      // 4: simultaneous press on both channels (ch1 active low)
      sw = 2'b01;
      n = 0;
      while (st != 2'b11 && n < 30) begin tick(); n++; end
      chk_int("dual_latency", n, SS + DL);
      tick();
      chk("dual_press", pr, 2'b11);
      ticks(8);
      sw = 2'b10;
      ticks(20);
      $display("step4 dual press done");

      // 5: repeat-disabled instance: one long, no repeats over a 100-cycle hold
      sw[0] = 1'b1;
      n_long_nr = 0; n_rep_nr = 0;
      for (int i = 0; i < SS + DL + 100; i++) begin
         tick();
         if (lg_n[0]) n_long_nr++;
         if (rp_n[0]) n_rep_nr++;
      end
      chk_int("nr_long_count", n_long_nr, 1);
      chk_int("nr_repeat_count", n_rep_nr, 0);
      sw[0] = 1'b0;
      ticks(20);
      $display("step5 repeat-disabled hold done");

      // 6: reset mid-hold with the pin held
      sw[0] = 1'b1;
      n = 0;
      while (!st[0] && n < 30) begin tick(); n++; end
      ticks(15);
      rst_n = 1'b0;
      #1;
      chk("rst_state", st, 2'b00);
      chk("rst_press", pr | rl, 2'b00);
      chk("rst_long", lg | rp, 2'b00);
      chk("rst_nr", st_n | pr_n | rl_n | lg_n | rp_n, 2'b00);
      model_reset();
      ticks(3);
      rst_n = 1'b1;
      n = 0;
      while (!st[0] && n < 30) begin tick(); n++; end
      chk_int("rst_recommit_latency", n, SS + DL);
      tick();
      chk("rst_repress", pr, 2'b01);
      n = 1;
      while (!lg[0] && n < 40) begin tick(); n++; end
      chk_int("rst_long_offset", n, LL);
      sw[0] = 1'b0;
      ticks(20);
      $display("step6 mid-hold reset done");

      // Random activity on both channels, mostly short with occasional long holds
      for (int seg = 0; seg < 60; seg++) begin
         sw  = 2'($urandom);
         dur = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 9);
         ticks(dur);
      end
      sw = 2'b10;
      ticks(20);
      $display("random phase done");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
